mc_hit_counter: RTL and testbench
=================================

// Module: mc_hit_counter
// PURPOSE
//  Downstream consumer of the a*x+b*y function stage in the Monte-Carlo datapath.
//  Issues enable_func strobes to that stage and tracks its 1-cycle result latency.
//  Classifies each returned t against a threshold and counts hits over a fixed batch.
//  Presents hit/sample totals to the result/estimator logic.
// PARAMETERS
//  WIDTH      10    operand width of the function stage; t and threshold are 2*WIDTH+1 bits
//  N_SAMPLES  1024  samples per batch, >= 1
//  CNT_W      $clog2(N_SAMPLES+1)  counter width (derived, do not override)
// PORTS
//  clk          in   1           rising-edge clock
//  rst          in   1           asynchronous reset, active-high
//  start        in   1           begin a batch (sampled in IDLE or DONE only)
//  abort        in   1           terminate the current batch
//  rng_valid    in   1           upstream random x/y/a/b operands valid this cycle
//  threshold    in   2*WIDTH+1   hit bound; t <= threshold is a hit; held stable during a batch
//  t            in   2*WIDTH+1   registered result from the function stage
//  enable_func  out  1           enable to the function stage (combinational from state/counters)
//  busy         out  1           1 in RUN
//  done         out  1           1 in DONE (level)
//  hits         out  CNT_W       hits in the current/last batch
//  samples      out  CNT_W       results consumed in the current/last batch
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE; issued=0; samples=0; hits=0; valid_d=0; done=0; busy=0.
//  - enable_func = (state==RUN) && rng_valid && (issued < N_SAMPLES) && !abort.
//  - valid_d <= enable_func every cycle; t is valid in the cycle where valid_d==1 (1-cycle latency).
//  - When valid_d==1 and state==RUN: samples += 1; hits += (t <= threshold) (unsigned compare).
//  - issued increments on every cycle with enable_func==1; never exceeds N_SAMPLES.
//  - FSM:
//     IDLE: start=1 -> RUN; clear issued, samples, hits in the same edge.
//     RUN : abort=1 -> IDLE (wins over everything; in-flight valid_d result discarded;
//           hits/samples keep the partial values).
//           samples reaches N_SAMPLES (i.e. the edge that makes samples==N_SAMPLES) -> DONE.
//     DONE: hits/samples frozen; start=1 -> RUN with counters cleared; abort ignored.
//  - start in RUN is ignored. start and abort together in IDLE/DONE: start wins (abort meaningless there).
//  - rng_valid gaps stall issue only; pending valid_d still counted.
//  - The final sample: issued hits N_SAMPLES, the next cycle's valid_d counts it, then DONE.
//    Minimum batch time with rng_valid stuck at 1: N_SAMPLES+1 cycles from the RUN entry edge to DONE.
//  - Counters cannot wrap: CNT_W holds N_SAMPLES; hits <= samples <= issued always.
//  - valid_d from a cycle preceding entry to RUN never exists (enable_func=0 outside RUN).
// CONFIGURATION
//  MC_SUM_ACCUM_EN defined: extra output sum [2*WIDTH+CNT_W:0] (out), reset 0, cleared on
//    start, += t on every counted sample (hit or not), frozen in DONE, keeps partial on abort.
//  MC_SUM_ACCUM_EN undefined: port sum and its adder absent; all other behaviour identical.
// TESTING
//  1 rst during RUN after 5 samples -> all outputs 0, state IDLE immediately (no clk edge needed).
//  2 N_SAMPLES=8, rng_valid=1, threshold=100, t alternating 50/150 -> done after 9 cycles, hits=4, samples=8.
//  3 rng_valid toggling 1,0,1,0..., N_SAMPLES=8 -> exactly 8 enable_func pulses, samples=8, done=1.
//  4 t==threshold=300 on all samples -> hits==samples==N_SAMPLES; t=301 -> hits=0.
//  5 abort asserted when issued=3 -> IDLE next edge, samples=2 (in-flight dropped), enable_func=0 same cycle.
//  6 start pulsed in RUN -> ignored; start in DONE -> counters clear, new batch runs; with MC_SUM_ACCUM_EN
//    and t=1000 constant, N_SAMPLES=8 -> sum=8000.

Source files
------------

// File: rtl/mc_hit_counter.sv
// -----------------------------------------------------------------------------
// mc_hit_counter
//
// Purpose
//   Downstream consumer of the a*x+b*y function stage in the Monte-Carlo
//   datapath. It strobes enable_func into that stage whenever a fresh operand
//   set is available, tracks the stage's one-cycle result latency, and
//   classifies each returned t against a threshold. Hits and consumed samples
//   are counted over a fixed batch of N_SAMPLES results. The totals go to the
//   result/estimator logic.
//
// Parameters
//   WIDTH      operand width of the function stage (t is 2*WIDTH+1 bits)
//   N_SAMPLES  samples per batch (>= 1)
//   CNT_W      derived counter width, holds N_SAMPLES without wrapping
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous reset, active-high
//   start        in   begin a batch (honoured in IDLE or DONE only)
//   abort        in   terminate the running batch (ignored outside RUN)
//   rng_valid    in   upstream random operands valid this cycle
//   threshold    in   hit bound, t <= threshold is a hit; stable during a batch
//   t            in   registered result of the function stage
//   enable_func  out  issue strobe to the function stage (combinational)
//   busy         out  high while a batch runs
//   done         out  high (level) once a batch has completed
//   hits         out  hits in the current/last batch
//   samples      out  results consumed in the current/last batch
//   sum          out  (MC_SUM_ACCUM_EN only) sum of every counted t
//
// Configuration
//   MC_SUM_ACCUM_EN  when defined, adds the sum output and its accumulator.
//                    When undefined, the port and the adder are absent.
// -----------------------------------------------------------------------------
module mc_hit_counter #(
  parameter  int WIDTH     = 10,
  parameter  int N_SAMPLES = 1024,
  localparam int CNT_W     = $clog2(N_SAMPLES + 1),
  localparam int TW        = 2 * WIDTH + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             rng_valid,
  input  logic [TW-1:0]    threshold,
  input  logic [TW-1:0]    t,
  output logic             enable_func,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hits,
  output logic [CNT_W-1:0] samples
`ifdef MC_SUM_ACCUM_EN
  ,
  output logic [2*WIDTH+CNT_W:0] sum
`endif
);

  localparam logic [CNT_W-1:0] LP_N      = CNT_W'(N_SAMPLES);
  localparam logic [CNT_W-1:0] LP_N_LAST = CNT_W'(N_SAMPLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [CNT_W-1:0] r_issued;
  logic [CNT_W-1:0] r_samples;
  logic [CNT_W-1:0] r_hits;
  logic             r_vld_p1;

  logic             w_run;
  logic             w_enable;
  logic             w_count;
  logic             w_last;
  logic             w_clear;
  logic             w_hit;

  // Unsigned classification of a returned result against the bound.
  function automatic logic is_hit(input logic [TW-1:0] value,
                                  input logic [TW-1:0] bound);
    return (value <= bound);
  endfunction

  assign w_run = (r_state == S_RUN);

  // Issue is capped at N_SAMPLES, so the counters never need to saturate.
  // Abort also blocks issue in its own cycle, which keeps an aborted batch
  // from launching work nobody will consume.
  assign w_enable = w_run && rng_valid && (r_issued < LP_N) && !abort;

  // A result is consumed one cycle after its issue. Abort drops the in-flight
  // result, so it is not counted.
  assign w_count = w_run && r_vld_p1 && !abort;
  assign w_last  = w_count && (r_samples == LP_N_LAST);
  assign w_hit   = is_hit(t, threshold);

  // Start only matters outside RUN. Outside RUN it also overrides abort.
  assign w_clear = start && !w_run;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage p0 -> p1: issue. r_vld_p1 marks that t carries a fresh result.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
      r_issued <= '0;
    end else begin
      r_vld_p1 <= w_enable;
      if (w_clear) begin
        r_issued <= '0;
      end else if (w_enable) begin
        r_issued <= r_issued + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: consume the result and update the counters.
  // Outside RUN, w_count is 0, so the totals stay frozen in DONE and keep the
  // partial values after an abort.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_samples <= '0;
      r_hits    <= '0;
    end else if (w_clear) begin
      r_samples <= '0;
      r_hits    <= '0;
    end else if (w_count) begin
      r_samples <= r_samples + CNT_W'(1);
      r_hits    <= r_hits + CNT_W'(w_hit);
    end
  end

`ifdef MC_SUM_ACCUM_EN
  localparam int SUM_W = TW + CNT_W;

  logic [SUM_W-1:0] r_sum;

  // Accumulate every counted sample, whether or not it is a hit. The width is
  // sized for N_SAMPLES full-scale results, so the sum cannot wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum <= '0;
    end else if (w_clear) begin
      r_sum <= '0;
    end else if (w_count) begin
      r_sum <= r_sum + {{CNT_W{1'b0}}, t};
    end
  end

  assign sum = r_sum;
`endif

  assign enable_func = w_enable;
  assign busy        = w_run;
  assign done        = (r_state == S_DONE);
  assign hits        = r_hits;
  assign samples     = r_samples;

endmodule

// File: tb/tb_mc_hit_counter.sv
// -----------------------------------------------------------------------------
// tb_mc_hit_counter
// Self-checking bench for mc_hit_counter with N_SAMPLES=8.
// The bench emulates the one-cycle function stage: t is registered from fval
// whenever enable_func is high. A queue-based batch model predicts the
// expected enable_func, busy, done, hits and samples values.
// -----------------------------------------------------------------------------
module tb_mc_hit_counter;

  localparam int WIDTH = 10;
  localparam int N     = 8;
  localparam int CNT_W = $clog2(N + 1);
  localparam int TW    = 2 * WIDTH + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic             rng_valid;
  logic [TW-1:0]    threshold;
  logic [TW-1:0]    t;
  logic [TW-1:0]    fval;
  logic             enable_func;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] hits;
  logic [CNT_W-1:0] samples;
`ifdef MC_SUM_ACCUM_EN
  logic [TW+CNT_W-1:0] sum;
`endif

  mc_hit_counter #(.WIDTH(WIDTH), .N_SAMPLES(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .rng_valid   (rng_valid),
    .threshold   (threshold),
    .t           (t),
    .enable_func (enable_func),
    .busy        (busy),
    .done        (done),
    .hits        (hits),
    .samples     (samples)
`ifdef MC_SUM_ACCUM_EN
    ,
    .sum         (sum)
`endif
  );

  always #5 clk = ~clk;

  // Function stage stand-in: the result appears on t one cycle after enable.
  always @(posedge clk or posedge rst) begin
    if (rst) t <= '0;
    else if (enable_func) t <= fval;
  end

  int checks   = 0;
  int failures = 0;

  // Batch-level reference model: 0=idle 1=running 2=finished.
  int     m_mode;
  int     m_issued;
  int     m_samples;
  int     m_hits;
  longint m_sum;
  int     pend[$];

  task automatic model_reset();
    m_mode = 0; m_issued = 0; m_samples = 0; m_hits = 0; m_sum = 0;
    pend.delete();
  endtask

  // Drive one cycle of inputs, report the enable seen vs predicted, then
  // advance the model across the clock edge.
  task automatic run_cycle(input bit s, input bit a, input bit rv,
                           input logic [TW-1:0] f,
                           output bit en_dut, output bit en_exp);
    int v;
    @(negedge clk);
    start = s; abort = a; rng_valid = rv; fval = f;
    #1;
    en_exp = (m_mode == 1) && rv && (m_issued < N) && !a;
    en_dut = enable_func;
    @(posedge clk);
    if (m_mode != 1) begin
      if (s) begin
        m_mode = 1; m_issued = 0; m_samples = 0; m_hits = 0; m_sum = 0;
        pend.delete();
      end
    end else if (a) begin
      m_mode = 0;
      pend.delete();
    end else begin
      if (pend.size() > 0) begin
        v = pend.pop_front();
        m_samples++;
        m_sum += v;
        if (v <= int'(threshold)) m_hits++;
        if (m_samples == N) m_mode = 2;
      end
      if (en_exp) begin
        pend.push_back(int'(f));
        m_issued++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    bit ed, ee;
    int n;
    rst = 1'b0; start = 0; abort = 0; rng_valid = 1; fval = '0; threshold = 21'd100;
    #1 rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, enable_func} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctrl: busy/done/en=%b required 000", {busy, done, enable_func});
    end
    checks++;
    if (hits !== 0 || samples !== 0) begin
      failures++;
      $display("FAIL reset_cnt: hits=%0d samples=%0d required 0/0", hits, samples);
    end
    @(negedge clk) rst = 1'b0;
    // Run 5 samples, then assert reset between clock edges.
    run_cycle(1, 0, 1, 21'd10, ed, ee);
    n = 0;
    while (m_samples < 5 && n < 20) begin
      n++;
      run_cycle(0, 0, 1, 21'd10, ed, ee);
    end
    checks++;
    if (samples !== 5 || busy !== 1'b1) begin
      failures++;
      $display("FAIL pre_rst_run: samples=%0d busy=%b required 5/1", samples, busy);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, enable_func} !== 3'b000 || hits !== 0 || samples !== 0) begin
      failures++;
      $display("FAIL async_rst: busy=%b done=%b en=%b hits=%0d samples=%0d required all 0",
               busy, done, enable_func, hits, samples);
    end
    model_reset();
    #1 rst = 1'b0;
  endtask

  task automatic test_alternating();
    bit ed, ee;
    int n, k;
    threshold = 21'd100;
    run_cycle(1, 0, 1, 21'd50, ed, ee);
    n = 0; k = 0;
    while (done !== 1'b1 && n < 30) begin
      n++;
      run_cycle(0, 0, 1, (k % 2 == 0) ? 21'd50 : 21'd150, ed, ee);
      if (ee) k++;
      checks++;
      if (ed !== ee) begin
        failures++;
        $display("FAIL alt_enable cycle %0d: got %b required %b", n, ed, ee);
      end
    end
    checks++;
    if (n !== N + 1) begin
      failures++;
      $display("FAIL alt_latency: done after %0d cycles required %0d", n, N + 1);
    end
    checks++;
    if (hits !== 4 || samples !== N || done !== 1'b1) begin
      failures++;
      $display("FAIL alt_totals: hits=%0d samples=%0d done=%b required 4/%0d/1",
               hits, samples, done, N);
    end
  endtask

  task automatic test_gaps();
    bit ed, ee;
    int n, pulses;
    threshold = 21'd500;
    run_cycle(1, 0, 0, 21'd7, ed, ee);
    n = 0; pulses = 0;
    while (done !== 1'b1 && n < 40) begin
      n++;
      run_cycle(0, 0, (n % 2) == 1, 21'd7, ed, ee);
      if (ed) pulses++;
      checks++;
      if (ed !== ee) begin
        failures++;
        $display("FAIL gap_enable cycle %0d: got %b required %b", n, ed, ee);
      end
    end
    repeat (4) begin
      run_cycle(0, 0, 1, 21'd7, ed, ee);
      if (ed) pulses++;
    end
    checks++;
    if (pulses !== N) begin
      failures++;
      $display("FAIL gap_pulses: got %0d required %0d", pulses, N);
    end
    checks++;
    if (samples !== N || done !== 1'b1 || hits !== N) begin
      failures++;
      $display("FAIL gap_totals: samples=%0d hits=%0d done=%b required %0d/%0d/1",
               samples, hits, done, N, N);
    end
  endtask

  task automatic test_threshold_edge();
    bit ed, ee;
    int n;
    logic [TW-1:0] tv;
    threshold = 21'd300;
    for (int r = 0; r < 2; r++) begin
      tv = (r == 0) ? 21'd300 : 21'd301;
      run_cycle(1, 0, 1, tv, ed, ee);
      n = 0;
      while (done !== 1'b1 && n < 20) begin
        n++;
        run_cycle(0, 0, 1, tv, ed, ee);
      end
      checks++;
      if (hits !== ((r == 0) ? N : 0) || samples !== N) begin
        failures++;
        $display("FAIL thr_edge t=%0d: hits=%0d samples=%0d required %0d/%0d",
                 tv, hits, samples, (r == 0) ? N : 0, N);
      end
    end
  endtask

  task automatic test_abort();
    bit ed, ee;
    int n, pulses;
    threshold = 21'd1000;
    run_cycle(1, 0, 1, 21'd5, ed, ee);
    n = 0; pulses = 0;
    while (pulses < 3 && n < 20) begin
      n++;
      run_cycle(0, 0, 1, 21'd5, ed, ee);
      if (ed) pulses++;
    end
    run_cycle(0, 1, 1, 21'd5, ed, ee);
    checks++;
    if (ed !== 1'b0) begin
      failures++;
      $display("FAIL abort_en_same_cycle: got %b required 0", ed);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || samples !== 2 || hits !== 2) begin
      failures++;
      $display("FAIL abort_state: busy=%b done=%b samples=%0d hits=%0d required 0/0/2/2",
               busy, done, samples, hits);
    end
    repeat (3) run_cycle(0, 0, 1, 21'd5, ed, ee);
    checks++;
    if (ed !== 1'b0 || samples !== 2) begin
      failures++;
      $display("FAIL abort_idle_hold: en=%b samples=%0d required 0/2", ed, samples);
    end
  endtask

  task automatic test_start_in_run_and_done();
    bit ed, ee;
    int n;
    threshold = 21'd2000;
    run_cycle(1, 0, 1, 21'd1000, ed, ee);
    n = 0;
    while (done !== 1'b1 && n < 30) begin
      n++;
      run_cycle((n % 3) == 0, 0, 1, 21'd1000, ed, ee);
    end
    checks++;
    if (n !== N + 1 || samples !== N || hits !== N) begin
      failures++;
      $display("FAIL start_in_run: cycles=%0d samples=%0d hits=%0d required %0d/%0d/%0d",
               n, samples, hits, N + 1, N, N);
    end
`ifdef MC_SUM_ACCUM_EN
    checks++;
    if (sum !== (TW + CNT_W)'(8000)) begin
      failures++;
      $display("FAIL sum_total: got %0d required 8000", sum);
    end
`endif
    run_cycle(0, 1, 1, 21'd1000, ed, ee);
    checks++;
    if (done !== 1'b1 || samples !== N) begin
      failures++;
      $display("FAIL abort_in_done: done=%b samples=%0d required 1/%0d", done, samples, N);
    end
    // Back to back: start together with abort out of DONE restarts the batch.
    run_cycle(1, 1, 1, 21'd1000, ed, ee);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || samples !== 0 || hits !== 0) begin
      failures++;
      $display("FAIL restart_from_done: busy=%b done=%b samples=%0d hits=%0d required 1/0/0/0",
               busy, done, samples, hits);
    end
    n = 0;
    while (done !== 1'b1 && n < 30) begin
      n++;
      run_cycle(0, 0, 1, 21'd3000, ed, ee);
    end
    checks++;
    if (samples !== N || hits !== 0 || n !== N + 1) begin
      failures++;
      $display("FAIL second_batch: samples=%0d hits=%0d cycles=%0d required %0d/0/%0d",
               samples, hits, n, N, N + 1);
    end
  endtask

  task automatic test_random();
    bit ed, ee, s, a, rv;
    logic [TW-1:0] f;
    for (int c = 0; c < 800; c++) begin
      if (m_mode != 1 && $urandom_range(0, 3) == 0) threshold = TW'($urandom_range(0, 2000));
      s  = ($urandom_range(0, 9) == 0);
      a  = ($urandom_range(0, 39) == 0);
      rv = ($urandom_range(0, 9) < 7);
      f  = ($urandom_range(0, 7) == 0) ? threshold : TW'($urandom_range(0, 4000));
      run_cycle(s, a, rv, f, ed, ee);
      checks++;
      if (ed !== ee) begin
        failures++;
        $display("FAIL rnd_enable c=%0d: got %b required %b", c, ed, ee);
      end
      checks++;
      if (busy !== (m_mode == 1) || done !== (m_mode == 2)) begin
        failures++;
        $display("FAIL rnd_state c=%0d: busy=%b done=%b required mode %0d", c, busy, done, m_mode);
      end
      checks++;
      if (samples !== CNT_W'(m_samples) || hits !== CNT_W'(m_hits)) begin
        failures++;
        $display("FAIL rnd_counts c=%0d: samples=%0d hits=%0d required %0d/%0d",
                 c, samples, hits, m_samples, m_hits);
      end
`ifdef MC_SUM_ACCUM_EN
      checks++;
      if (sum !== (TW + CNT_W)'(m_sum)) begin
        failures++;
        $display("FAIL rnd_sum c=%0d: got %0d required %0d", c, sum, m_sum);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_alternating();
    test_gaps();
    test_threshold_edge();
    test_abort();
    test_start_in_run_and_done();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
